// File: rtl/ines_loader_if.sv
// iNES loader bus bundle.
//   in_*  : byte stream from the image source (valid/ready handshake)
//   mem_* : registered single-byte write request to the target memory
//   mapper_flags/done/error/err_code : decoded header and load status
// master = loader side, slave = environment (source + memory) side.
interface ines_loader_if #(
  parameter int unsigned ADDR_W = 22
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_write;
  logic              mem_ready;
  logic [31:0]       mapper_flags;
  logic              done;
  logic              error;
  logic [1:0]        err_code;

  modport master (
    input  in_data, in_valid, mem_ready,
    output in_ready, mem_addr, mem_data, mem_write, mapper_flags, done, error, err_code
  );

  modport slave (
    output in_data, in_valid, mem_ready,
    input  in_ready, mem_addr, mem_data, mem_write, mapper_flags, done, error, err_code
  );
endinterface

// File: rtl/ines_loader.sv
// iNES / NES2.0 ROM image loader.
// Parses the 16-byte header, optionally skips or stores the 512-byte trainer, then streams
// PRG bytes from PRG_BASE and CHR bytes from CHR_BASE as single-byte memory writes.
// Ports: clk, reset_n (async, active low); bus (ines_loader_if.master) carries the input
// byte stream, the memory write port and the header/status outputs.
module ines_loader #(
  parameter int unsigned       ADDR_W       = 22,
  parameter logic [ADDR_W-1:0] PRG_BASE     = '0,
  parameter logic [ADDR_W-1:0] CHR_BASE     = 22'h200000,
  parameter bit                TRAINER_LOAD = 1'b0,
  parameter logic [ADDR_W-1:0] TRAINER_BASE = 22'h3FFE00
) (
  input logic            clk,
  input logic            reset_n,
  ines_loader_if.master  bus
);

  localparam int unsigned CntW     = 27;
  localparam logic [63:0] PrgSpace = 64'(CHR_BASE) - 64'(PRG_BASE);
  localparam logic [63:0] ChrSpace = (64'd1 << ADDR_W) - 64'(CHR_BASE);

  typedef enum logic [2:0] {StHdr, StTrn, StPrg, StChr, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [7:0]        hdr_q [16];
  logic [7:0]        hdr_w [16];
  logic [3:0]        hdr_cnt_q, hdr_cnt_d;
  logic              run_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CntW-1:0]   remain_q, remain_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              mem_write_q, mem_write_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              in_ready, xfer, take_write;
  logic              nes2, dirty, magic_ok, prg_ovf, chr_ovf;
  logic [11:0]       prg_pages, chr_pages;
  logic [CntW-1:0]   prg_bytes, chr_bytes;
  logic [31:0]       flags;

  // Smallest n with pages <= 2^n, saturating at 7.
  function automatic logic [2:0] size_log2(input logic [11:0] pages);
    logic [2:0] n;
    n = 3'd7;
    for (int i = 6; i >= 0; i--) begin
      if (32'(pages) <= (32'd1 << i)) n = 3'(i);
    end
    return n;
  endfunction

  // A region with remain_q == 0 is draining its last write; no more bytes are taken.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      StHdr:               in_ready = run_q;
      StTrn, StPrg, StChr: in_ready = (remain_q != '0) && (!mem_write_q || bus.mem_ready);
      default:             in_ready = 1'b0;
    endcase
  end

  assign xfer = bus.in_valid && in_ready;

  // Header view including the byte arriving this cycle, so the 16th byte decodes immediately.
  always_comb begin
    hdr_w = hdr_q;
    if (state_q == StHdr && xfer) hdr_w[hdr_cnt_q] = bus.in_data;
  end

  always_comb begin
    nes2      = (hdr_w[7][3:2] == 2'b10);
    dirty     = !nes2 && (|{hdr_w[8], hdr_w[9], hdr_w[10], hdr_w[11],
                            hdr_w[12], hdr_w[13], hdr_w[14], hdr_w[15]});
    magic_ok  = ({hdr_w[0], hdr_w[1], hdr_w[2], hdr_w[3]} == 32'h4E45_531A);
    prg_pages = nes2 ? {hdr_w[9][3:0], hdr_w[4]} : {4'b0, hdr_w[4]};
    chr_pages = nes2 ? {hdr_w[9][7:4], hdr_w[5]} : {4'b0, hdr_w[5]};
    prg_bytes = CntW'(prg_pages) << 14;
    chr_bytes = CntW'(chr_pages) << 13;
    prg_ovf   = 64'(prg_bytes) > PrgSpace;
    chr_ovf   = 64'(chr_bytes) > ChrSpace;

    flags        = '0;
    flags[7:0]   = {dirty ? 4'h0 : hdr_w[7][7:4], hdr_w[6][7:4]};
    flags[10:8]  = size_log2(prg_pages);
    flags[13:11] = size_log2(chr_pages);
    flags[14]    = hdr_w[6][0];
    flags[15]    = (chr_pages == 12'd0);
    flags[16]    = hdr_w[6][3];
    flags[17]    = hdr_w[6][1];
    flags[18]    = hdr_w[6][2];
    flags[22:19] = nes2 ? hdr_w[8][3:0] : 4'h0;
    flags[26:23] = nes2 ? hdr_w[8][7:4] : 4'h0;
    flags[27]    = nes2;
  end

  always_comb begin
    state_d     = state_q;
    hdr_cnt_d   = hdr_cnt_q;
    addr_d      = addr_q;
    remain_d    = remain_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_write_d = mem_write_q && !bus.mem_ready;
    err_code_d  = err_code_q;
    take_write  = 1'b0;

    case (state_q)
      StHdr: begin
        if (xfer) begin
          hdr_cnt_d = hdr_cnt_q + 4'd1;
          if (hdr_cnt_q == 4'd15) begin
            if (!magic_ok) begin
              state_d    = StErr;
              err_code_d = 2'd1;
            end else if (prg_pages == 12'd0) begin
              state_d    = StErr;
              err_code_d = 2'd2;
            end else if (prg_ovf || chr_ovf) begin
              state_d    = StErr;
              err_code_d = 2'd3;
            end else if (hdr_w[6][2]) begin
              state_d  = StTrn;
              remain_d = CntW'(512);
              addr_d   = TRAINER_BASE;
            end else begin
              state_d  = StPrg;
              remain_d = prg_bytes;
              addr_d   = PRG_BASE;
            end
          end
        end
      end
      StTrn: begin
        if (xfer) begin
          take_write = TRAINER_LOAD;
          addr_d     = addr_q + ADDR_W'(1);
          remain_d   = remain_q - CntW'(1);
          if (remain_q == CntW'(1)) begin
            state_d  = StPrg;
            remain_d = prg_bytes;
            addr_d   = PRG_BASE;
          end
        end
      end
      StPrg: begin
        if (xfer) begin
          take_write = 1'b1;
          addr_d     = addr_q + ADDR_W'(1);
          remain_d   = remain_q - CntW'(1);
          // Switch on the last PRG byte so the first CHR byte follows with no bubble.
          if (remain_q == CntW'(1) && chr_pages != 12'd0) begin
            state_d  = StChr;
            remain_d = chr_bytes;
            addr_d   = CHR_BASE;
          end
        end else if (remain_q == '0 && !mem_write_d) begin
          state_d = StDone;
        end
      end
      StChr: begin
        if (xfer) begin
          take_write = 1'b1;
          addr_d     = addr_q + ADDR_W'(1);
          remain_d   = remain_q - CntW'(1);
        end else if (remain_q == '0 && !mem_write_d) begin
          state_d = StDone;
        end
      end
      default: ;
    endcase

    if (take_write) begin
      mem_addr_d  = addr_q;
      mem_data_d  = bus.in_data;
      mem_write_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StHdr;
      hdr_cnt_q   <= '0;
      run_q       <= 1'b0;
      addr_q      <= '0;
      remain_q    <= '0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_write_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      hdr_cnt_q   <= hdr_cnt_d;
      run_q       <= 1'b1;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_write_q <= mem_write_d;
      err_code_q  <= err_code_d;
    end
  end

  // Header storage needs no reset; its contents are only used after 16 fresh bytes.
  always_ff @(posedge clk) begin
    hdr_q <= hdr_w;
  end

  assign bus.in_ready     = in_ready;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data     = mem_data_q;
  assign bus.mem_write    = mem_write_q;
  assign bus.mapper_flags = flags;
  assign bus.done         = (state_q == StDone);
  assign bus.error        = (state_q == StErr);
  assign bus.err_code     = err_code_q;

endmodule

// File: tb/tb_ines_loader.sv
// Scoreboard bench for ines_loader: the stimulus pushes expected (addr, data) writes,
// a monitor pops them as the memory accepts each write.
module tb_ines_loader;
  localparam int unsigned AddrW   = 22;
  localparam longint      PrgBase = 64'h0;
  localparam longint      ChrBase = 64'h200000;

  typedef struct {
    logic [AddrW-1:0] addr;
    logic [7:0]       data;
  } wr_t;

  logic clk;
  logic reset_n;
  ines_loader_if #(.ADDR_W(AddrW)) bus ();

  ines_loader #(
    .ADDR_W      (AddrW),
    .PRG_BASE    (22'h0),
    .CHR_BASE    (22'h200000),
    .TRAINER_LOAD(1'b0),
    .TRAINER_BASE(22'h3FFE00)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  wr_t exp_q[$];
  int  checks;
  int  errors;
  int  writes_seen;
  bit  ready_random;
  bit  gaps;
  bit  stalled;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory side: ready changes only just after the rising edge.
  initial begin
    bus.mem_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready = ready_random ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: a write is accepted at the next rising edge when mem_write && mem_ready here.
  initial begin
    bit               pend;
    logic [AddrW-1:0] pa;
    logic [7:0]       pd;
    wr_t              e;
    pend = 1'b0;
    pa   = '0;
    pd   = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          check("hold_write", 64'(bus.mem_write), 64'(1));
          check("hold_addr", 64'(bus.mem_addr), 64'(pa));
          check("hold_data", 64'(bus.mem_data), 64'(pd));
        end
        if (bus.mem_write && bus.mem_ready) begin
          writes_seen++;
          check("write_expected", 64'(exp_q.size() != 0), 64'(1));
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("write_addr", 64'(bus.mem_addr), 64'(e.addr));
            check("write_data", 64'(bus.mem_data), 64'(e.data));
          end
        end
        pend = bus.mem_write && !bus.mem_ready;
        pa   = bus.mem_addr;
        pd   = bus.mem_data;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    if (gaps && $urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (!bus.in_ready) begin
      check("in_ready_timeout", 64'(bus.in_ready), 64'(1));
      stalled = 1'b1;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    #1;
    check("rst_mem_write", 64'(bus.mem_write), 64'(0));
    check("rst_mem_addr", 64'(bus.mem_addr), 64'(0));
    check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_error", 64'(bus.error), 64'(0));
    check("rst_err_code", 64'(bus.err_code), 64'(0));
    repeat (3) @(posedge clk);
    #1;
    exp_q.delete();
    stalled = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_release_in_ready", 64'(bus.in_ready), 64'(1));
  endtask

  function automatic int size_of(input int pages);
    int n;
    n = 0;
    while (n < 7 && pages > (1 << n)) n++;
    return n;
  endfunction

  function automatic logic [31:0] model_flags(input logic [7:0] h[16]);
    bit          nes2;
    bit          dirty;
    int          prg;
    int          chr;
    int          mapper;
    logic [31:0] f;
    nes2  = (h[7] & 8'h0C) == 8'h08;
    dirty = 1'b0;
    for (int i = 8; i < 16; i++) if (h[i] != 8'h00 && !nes2) dirty = 1'b1;
    prg    = nes2 ? int'(h[9] & 8'h0F) * 256 + int'(h[4]) : int'(h[4]);
    chr    = nes2 ? int'(h[9] >> 4) * 256 + int'(h[5]) : int'(h[5]);
    mapper = int'(h[6] >> 4) + (dirty ? 0 : int'(h[7] >> 4) * 16);
    f = 32'(mapper) | (32'(size_of(prg)) << 8) | (32'(size_of(chr)) << 11)
      | (32'(h[6][0]) << 14) | (32'(chr == 0) << 15) | (32'(h[6][3]) << 16)
      | (32'(h[6][1]) << 17) | (32'(h[6][2]) << 18);
    if (nes2) f = f | (32'(h[8] & 8'h0F) << 19) | (32'(h[8] >> 4) << 23) | (32'd1 << 27);
    return f;
  endfunction

  // Loads one image. abort_after >= 0 resets the DUT after that many PRG/CHR bytes.
  task automatic run_image(input string name, input logic [7:0] h[16], input int abort_after);
    bit     nes2;
    int     err;
    longint prg;
    longint chr;
    int     sent;
    int     w;
    int     start_writes;
    bit     aborted;
    logic [7:0] d;
    wr_t    e;
    nes2 = (h[7] & 8'h0C) == 8'h08;
    prg  = nes2 ? longint'(h[9] & 8'h0F) * 256 + longint'(h[4]) : longint'(h[4]);
    chr  = nes2 ? longint'(h[9] >> 4) * 256 + longint'(h[5]) : longint'(h[5]);
    prg  = prg * 16384;
    chr  = chr * 8192;
    if (!(h[0] == 8'h4E && h[1] == 8'h45 && h[2] == 8'h53 && h[3] == 8'h1A)) err = 1;
    else if (prg == 0) err = 2;
    else if (prg > ChrBase - PrgBase || chr > (longint'(1) << AddrW) - ChrBase) err = 3;
    else err = 0;

    start_writes = writes_seen;
    for (int i = 0; i < 16 && !stalled; i++) send_byte(h[i]);

    if (err != 0) begin
      repeat (3) @(posedge clk);
      #1;
      $display("image %s: expecting err_code %0d", name, err);
      check("err_error", 64'(bus.error), 64'(1));
      check("err_code", 64'(bus.err_code), 64'(err));
      check("err_in_ready", 64'(bus.in_ready), 64'(0));
      check("err_done", 64'(bus.done), 64'(0));
      check("err_no_writes", 64'(writes_seen - start_writes), 64'(0));
      return;
    end

    if (h[6][2]) begin
      for (int i = 0; i < 512 && !stalled; i++) send_byte(8'($urandom));
    end
    sent    = 0;
    aborted = 1'b0;
    for (longint i = 0; i < prg + chr && !stalled; i++) begin
      if (abort_after >= 0 && sent == abort_after) begin
        aborted = 1'b1;
        break;
      end
      d      = 8'($urandom);
      e.addr = (i < prg) ? AddrW'(PrgBase + i) : AddrW'(ChrBase + (i - prg));
      e.data = d;
      exp_q.push_back(e);
      send_byte(d);
      sent++;
    end

    check("flags", 64'(bus.mapper_flags), 64'(model_flags(h)));
    if (aborted) begin
      do_reset();
      return;
    end

    w = 0;
    while (!bus.done && w < 1000) begin
      @(negedge clk);
      w++;
    end
    $display("image %s: %0d PRG + %0d CHR bytes", name, prg, chr);
    check("done", 64'(bus.done), 64'(1));
    check("done_error", 64'(bus.error), 64'(0));
    check("done_in_ready", 64'(bus.in_ready), 64'(0));
    check("done_mem_write", 64'(bus.mem_write), 64'(0));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("write_count", 64'(writes_seen - start_writes), 64'(prg + chr));
    check("flags_after_done", 64'(bus.mapper_flags), 64'(model_flags(h)));
  endtask

  task automatic mk_hdr(output logic [7:0] h[16], input logic [7:0] b4, input logic [7:0] b5,
                        input logic [7:0] b6, input logic [7:0] b7);
    h[0] = 8'h4E;
    h[1] = 8'h45;
    h[2] = 8'h53;
    h[3] = 8'h1A;
    h[4] = b4;
    h[5] = b5;
    h[6] = b6;
    h[7] = b7;
    for (int i = 8; i < 16; i++) h[i] = 8'h00;
  endtask

  initial begin
    logic [7:0] h[16];
    checks       = 0;
    errors       = 0;
    writes_seen  = 0;
    ready_random = 1'b0;
    gaps         = 1'b0;
    stalled      = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    reset_n      = 1'b0;
    #2;
    do_reset();

    // Bad magic.
    mk_hdr(h, 8'd1, 8'd0, 8'h00, 8'h00);
    h[3] = 8'h00;
    run_image("bad_magic", h, -1);
    do_reset();

    // Zero PRG pages.
    mk_hdr(h, 8'd0, 8'd1, 8'h00, 8'h00);
    run_image("prg_zero", h, -1);
    do_reset();

    // NES2.0 with 256 PRG pages: 4 MiB does not fit the 2 MiB PRG window.
    mk_hdr(h, 8'd0, 8'd0, 8'h00, 8'h08);
    h[9] = 8'h01;
    run_image("prg_overflow", h, -1);
    do_reset();

    // NES2.0 extended fields; CHR = 256 pages exactly fills the CHR window.
    mk_hdr(h, 8'd1, 8'd0, 8'h50, 8'h08);
    h[8] = 8'h21;
    h[9] = 8'h10;
    run_image("nes2_flags", h, 0);

    // Plain iNES, mapper 1, random mirroring bit, memory always ready.
    mk_hdr(h, 8'd2, 8'd1, 8'h10 | 8'($urandom_range(0, 1)), 8'h00);
    run_image("mmc1_32k_8k", h, -1);
    do_reset();

    // Abort partway through PRG, then a fresh load with trainer, dirty header, stalls.
    ready_random = 1'b1;
    mk_hdr(h, 8'd1, 8'd1, 8'h40, 8'h00);
    run_image("abort_mid_prg", h, 1000);

    gaps = 1'b1;
    mk_hdr(h, 8'd1, 8'd0, 8'h24 | 8'($urandom_range(0, 1)) | 8'h08, 8'h30);
    h[12] = 8'h5A;
    run_image("trainer_dirty", h, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
